// File: rtl/tl_skid_fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tl_skid_pkg
//  Description : Shared helpers for the TileLink elastic buffer: count-width
//                function and parameter legality check.
//  Revision    : 1.0  initial release
// ============================================================================
package tl_skid_pkg;

  // Width needed to hold an occupancy value in the range 0..depth.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // DEPTH must be a power of two >= 2 so pointers wrap for free;
  // AF_LEVEL must be a reachable occupancy.
  function automatic bit params_ok(input int depth, input int af_level);
    return (depth >= 2) && ((depth & (depth - 1)) == 0) &&
           (af_level >= 1) && (af_level <= depth);
  endfunction

endpackage

`define TL_SKID_PARAMS_OK(depth, af_level) (tl_skid_pkg::params_ok((depth), (af_level)))

`default_nettype wire

// File: rtl/tl_skid_fifo_if.sv
`default_nettype none
// ============================================================================
//  Module      : tl_skid_fifo_if
//  Description : Bus-side / IP-side handshake bundle of the elastic buffer.
//                slave = buffer side, master = environment side.
//  Revision    : 1.0  initial release
// ============================================================================
interface tl_skid_fifo_if #(
  parameter int DW    = 8,
  parameter int DEPTH = 2
);
  import tl_skid_pkg::*;

  localparam int CW = cnt_w(DEPTH);

  logic          flush_i;
  logic          registered_vld_i;
  logic [DW-1:0] registered_data_i;
  logic          registered_ready_o;
  logic          cycle_vld_o;
  logic [DW-1:0] cycle_data_o;
  logic          combinational_ready_i;
  logic [CW-1:0] count_o;
  logic          almost_full_o;

  modport slave (
    input  flush_i, registered_vld_i, registered_data_i, combinational_ready_i,
    output registered_ready_o, cycle_vld_o, cycle_data_o, count_o, almost_full_o
  );

  modport master (
    output flush_i, registered_vld_i, registered_data_i, combinational_ready_i,
    input  registered_ready_o, cycle_vld_o, cycle_data_o, count_o, almost_full_o
  );

endinterface

`default_nettype wire

// File: rtl/tl_skid_fifo_ram.sv
`default_nettype none
// ============================================================================
//  Module      : tl_skid_ram
//  Description : DEPTH x DW storage, one synchronous write port and one
//                asynchronous read port. Contents are not reset.
//  Revision    : 1.0  initial release
// ============================================================================
module tl_skid_ram
  import tl_skid_pkg::*;
#(
  parameter int DW    = 8,
  parameter int DEPTH = 2
) (
  input  wire logic                     clk_i,
  input  wire logic                     we_i,
  input  wire logic [$clog2(DEPTH)-1:0] waddr_i,
  input  wire logic [DW-1:0]            wdata_i,
  input  wire logic [$clog2(DEPTH)-1:0] raddr_i,
  output      logic [DW-1:0]            rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];

  // Write port: storage only, no reset needed since occupancy gates reads.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

`default_nettype wire

// File: rtl/tl_skid_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tl_skid_fifo
//  Description : DEPTH-entry elastic buffer for a TileLink channel boundary.
//                Bus side sees a flop-driven ready; IP side sees valid/data
//                either combinationally (head or bypass) or from an output
//                register, selected by OUT_REG.
//  Revision    : 1.0  initial release
// ============================================================================
module tl_skid_fifo
  import tl_skid_pkg::*;
#(
  parameter int DW       = 8,
  parameter int DEPTH    = 2,
  parameter int OUT_REG  = 0,
  parameter int AF_LEVEL = DEPTH - 1
) (
  input  wire logic     clk_i,
  input  wire logic     rst_i,
  tl_skid_fifo_if.slave bus_if
);

  localparam int            CW          = cnt_w(DEPTH);
  localparam int            AW          = $clog2(DEPTH);
  localparam logic [CW-1:0] c_depth_cnt = CW'(DEPTH);
  localparam logic [CW-1:0] c_af_cnt    = CW'(AF_LEVEL);

  if (!`TL_SKID_PARAMS_OK(DEPTH, AF_LEVEL)) begin : g_param_err
    $error("tl_skid_fifo: DEPTH must be a power of two >= 2 and AF_LEVEL in 1..DEPTH");
  end

  logic          flush;
  logic          push;
  logic          pop;
  logic [CW-1:0] count_q, count_d;
  logic          ready_q, ready_d;
  logic          af_q, af_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic          ram_we;
  logic          rd_adv;
  logic [DW-1:0] ram_rdata;
  logic          cycle_vld;
  logic [DW-1:0] cycle_data;

  assign flush = bus_if.flush_i;
  assign push  = bus_if.registered_vld_i & ready_q;
  assign pop   = cycle_vld & bus_if.combinational_ready_i;

  // Occupancy and the flags derived from it; flush overrides push and pop.
  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else begin
      count_d = count_q + CW'(push) - CW'(pop);
    end
    ready_d = (count_d < c_depth_cnt);
    af_d    = (count_d >= c_af_cnt);
  end

  // Pointer advance; flush realigns both pointers to the start.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (ram_we) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_adv) rd_ptr_d = rd_ptr_q + AW'(1);
    end
  end

  // Control state: ready comes up one edge after reset release.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q  <= '0;
      ready_q  <= 1'b0;
      af_q     <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      count_q  <= count_d;
      ready_q  <= ready_d;
      af_q     <= af_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  tl_skid_ram #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (ram_we),
    .waddr_i (wr_ptr_q),
    .wdata_i (bus_if.registered_data_i),
    .raddr_i (rd_ptr_q),
    .rdata_o (ram_rdata)
  );

  if (OUT_REG == 0) begin : g_comb_out
    logic empty;
    assign empty = (count_q == '0);

    // Head entry when holding data, otherwise a zero-latency bypass.
    // A bypassed beat popped in the same cycle never touches storage.
    assign cycle_vld  = !empty | (ready_q & bus_if.registered_vld_i);
    assign cycle_data = empty ? bus_if.registered_data_i : ram_rdata;
    assign ram_we     = push & !flush & !(empty & pop);
    assign rd_adv     = pop & !flush & !empty;
  end else begin : g_reg_out
    logic          out_vld_q, out_vld_d;
    logic [DW-1:0] out_data_q, out_data_d;
    logic          stored_empty;
    logic          need_load;

    // Storage holds everything except the beat parked in the output flop.
    assign stored_empty = (count_q == CW'(out_vld_q));
    assign need_load    = !out_vld_q | pop;

    // Output slot refill: storage first, else straight from the bus.
    always_comb begin
      out_vld_d  = out_vld_q;
      out_data_d = out_data_q;
      ram_we     = push & !flush;
      rd_adv     = 1'b0;
      if (flush) begin
        out_vld_d = 1'b0;
        ram_we    = 1'b0;
      end else if (need_load) begin
        if (!stored_empty) begin
          out_vld_d  = 1'b1;
          out_data_d = ram_rdata;
          rd_adv     = 1'b1;
        end else if (push) begin
          out_vld_d  = 1'b1;
          out_data_d = bus_if.registered_data_i;
          ram_we     = 1'b0;
        end else begin
          out_vld_d  = 1'b0;
        end
      end
    end

    // Output register, cleared by reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        out_vld_q  <= 1'b0;
        out_data_q <= '0;
      end else begin
        out_vld_q  <= out_vld_d;
        out_data_q <= out_data_d;
      end
    end

    assign cycle_vld  = out_vld_q;
    assign cycle_data = out_data_q;
  end

  assign bus_if.registered_ready_o = ready_q;
  assign bus_if.cycle_vld_o        = cycle_vld;
  assign bus_if.cycle_data_o       = cycle_data;
  assign bus_if.count_o            = count_q;
  assign bus_if.almost_full_o      = af_q;

endmodule

`default_nettype wire

// File: tb/tb_tl_skid_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tl_skid_fifo
//  Description : Self-checking bench for tl_skid_fifo. Two instances run side
//                by side: DEPTH=4/OUT_REG=0/AF=3 and DEPTH=2/OUT_REG=1/AF=1,
//                each compared against a queue model every cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_tl_skid_fifo;
  import tl_skid_pkg::*;

  localparam int DW  = 8;
  localparam int D0  = 4;
  localparam int AF0 = 3;
  localparam int D1  = 2;
  localparam int AF1 = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tl_skid_fifo_if #(.DW(DW), .DEPTH(D0)) if0 ();
  tl_skid_fifo_if #(.DW(DW), .DEPTH(D1)) if1 ();

  tl_skid_fifo #(.DW(DW), .DEPTH(D0), .OUT_REG(0), .AF_LEVEL(AF0)) dut0 (
    .clk_i (clk), .rst_i (rst), .bus_if (if0)
  );
  tl_skid_fifo #(.DW(DW), .DEPTH(D1), .OUT_REG(1), .AF_LEVEL(AF1)) dut1 (
    .clk_i (clk), .rst_i (rst), .bus_if (if1)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Reference model: beats currently held, plus the bus-side ready flag.
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  bit         rdy0 = 1'b0;
  bit         rdy1 = 1'b0;

  // Per-tick observations for directed sequences.
  bit         obs_pop0, obs_pop1, last_push0, last_push1;
  logic [7:0] obs_d0, obs_d1;
  int         tick_cyc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit exp_vld0();
    return (q0.size() != 0) || (rdy0 && if0.registered_vld_i);
  endfunction
  function automatic logic [7:0] exp_data0();
    return (q0.size() != 0) ? q0[0] : if0.registered_data_i;
  endfunction
  function automatic bit exp_vld1();
    return (q1.size() != 0);
  endfunction

  task automatic check_all();
    chk("vld0", if0.cycle_vld_o, exp_vld0());
    if (exp_vld0()) chk("data0", if0.cycle_data_o, exp_data0());
    chk("rdy0", if0.registered_ready_o, rdy0);
    chk("cnt0", if0.count_o, q0.size());
    chk("af0", if0.almost_full_o, q0.size() >= AF0);
    chk("ovf0", if0.registered_vld_i & if0.registered_ready_o & (if0.count_o == 3'd4), 0);
    chk("vld1", if1.cycle_vld_o, exp_vld1());
    if (exp_vld1()) chk("data1", if1.cycle_data_o, q1[0]);
    chk("rdy1", if1.registered_ready_o, rdy1);
    chk("cnt1", if1.count_o, q1.size());
    chk("af1", if1.almost_full_o, q1.size() >= AF1);
    chk("ovf1", if1.registered_vld_i & if1.registered_ready_o & (if1.count_o == 2'd2), 0);
  endtask

  // Called at a falling edge with inputs already driven.
  task automatic tick();
    bit p0, o0, f0, p1, o1, f1, byp;
    logic [7:0] d0, d1;
    #1;
    check_all();
    p0 = if0.registered_vld_i && rdy0;
    o0 = exp_vld0() && if0.combinational_ready_i;
    d0 = if0.registered_data_i;
    f0 = if0.flush_i;
    p1 = if1.registered_vld_i && rdy1;
    o1 = exp_vld1() && if1.combinational_ready_i;
    d1 = if1.registered_data_i;
    f1 = if1.flush_i;
    obs_pop0 = if0.cycle_vld_o && if0.combinational_ready_i;
    obs_d0   = if0.cycle_data_o;
    obs_pop1 = if1.cycle_vld_o && if1.combinational_ready_i;
    obs_d1   = if1.cycle_data_o;
    tick_cyc = cyc;
    @(posedge clk);
    if (rst) begin
      q0.delete(); q1.delete(); rdy0 = 1'b0; rdy1 = 1'b0;
      last_push0 = 1'b0; last_push1 = 1'b0;
    end else begin
      last_push0 = p0 && !f0;
      last_push1 = p1 && !f1;
      if (f0) q0.delete();
      else begin
        byp = (q0.size() == 0);
        if (o0 && !byp) void'(q0.pop_front());
        if (p0 && !(o0 && byp)) q0.push_back(d0);
      end
      if (f1) q1.delete();
      else begin
        if (o1) void'(q1.pop_front());
        if (p1) q1.push_back(d1);
      end
      rdy0 = (q0.size() < D0);
      rdy1 = (q1.size() < D1);
    end
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pop_d [16];
    int         pop_c [16];
    int         npop, nxt, first;

    if0.flush_i = 0; if0.registered_vld_i = 0; if0.registered_data_i = 0; if0.combinational_ready_i = 0;
    if1.flush_i = 0; if1.registered_vld_i = 0; if1.registered_data_i = 0; if1.combinational_ready_i = 0;

    // Reset state.
    @(negedge clk);
    tick();
    tick();
    chk("rst_data1", if1.cycle_data_o, 8'h00);
    rst = 1'b0;
    tick();
    chk("rel_rdy0", if0.registered_ready_o, 1'b1);

    // T1: zero-latency bypass of 0xA5.
    if0.registered_vld_i = 1; if0.registered_data_i = 8'hA5; if0.combinational_ready_i = 1;
    #1;
    chk("t1_vld", if0.cycle_vld_o, 1'b1);
    chk("t1_data", if0.cycle_data_o, 8'hA5);
    chk("t1_cnt", if0.count_o, 0);
    tick();
    if0.registered_vld_i = 0;
    tick();

    // T2: fill with IP stalled, 5th beat held upstream.
    if0.combinational_ready_i = 0;
    for (int i = 1; i <= 4; i++) begin
      if0.registered_vld_i = 1; if0.registered_data_i = 8'(i);
      tick();
    end
    if0.registered_data_i = 8'h05;
    #1;
    chk("t2_cnt", if0.count_o, 4);
    chk("t2_rdy", if0.registered_ready_o, 1'b0);
    chk("t2_af", if0.almost_full_o, 1'b1);
    tick();
    chk("t2_hold", if0.count_o, 4);

    // T3: drain in order, 0x05 accepted once space opens.
    if0.combinational_ready_i = 1;
    npop = 0;
    for (int t = 0; t < 20 && npop < 5; t++) begin
      tick();
      if (obs_pop0) begin pop_d[npop] = obs_d0; npop++; end
      if (last_push0) if0.registered_vld_i = 0;
    end
    chk("t3_npop", npop, 5);
    for (int k = 0; k < 5; k++) chk("t3_order", pop_d[k], k + 1);

    // T4: OUT_REG=1 streaming 0..9, no bubble after 1-cycle latency.
    if0.combinational_ready_i = 0;
    if1.combinational_ready_i = 1;
    nxt = 0; npop = 0; first = -1;
    for (int t = 0; t < 20 && npop < 10; t++) begin
      if1.registered_vld_i  = (nxt < 10);
      if1.registered_data_i = 8'(nxt);
      tick();
      if (obs_pop1) begin pop_d[npop] = obs_d1; pop_c[npop] = tick_cyc; npop++; end
      if (last_push1) begin
        if (first < 0) first = tick_cyc;
        nxt++;
      end
    end
    if1.registered_vld_i = 0;
    chk("t4_npop", npop, 10);
    for (int k = 0; k < 10; k++) begin
      chk("t4_data", pop_d[k], k);
      chk("t4_cycle", pop_c[k], first + 1 + k);
    end
    tick();

    // T5: flush with simultaneous push of 0x77 on both instances.
    if0.combinational_ready_i = 0; if1.combinational_ready_i = 0;
    for (int i = 0; i < 3; i++) begin
      if0.registered_vld_i = 1; if0.registered_data_i = 8'h10 + 8'(i);
      if1.registered_vld_i = 1; if1.registered_data_i = 8'h20 + 8'(i);
      tick();
    end
    chk("t5_cnt3", if0.count_o, 3);
    if0.flush_i = 1; if0.registered_data_i = 8'h77;
    if1.flush_i = 1; if1.registered_data_i = 8'h77;
    tick();
    if0.flush_i = 0; if0.registered_vld_i = 0;
    if1.flush_i = 0; if1.registered_vld_i = 0;
    #1;
    chk("t5_cnt0", if0.count_o, 0);
    chk("t5_rdy0", if0.registered_ready_o, 1'b1);
    chk("t5_af0", if0.almost_full_o, 1'b0);
    chk("t5_vld1", if1.cycle_vld_o, 1'b0);
    chk("t5_cnt1", if1.count_o, 0);
    if0.combinational_ready_i = 1; if1.combinational_ready_i = 1;
    for (int i = 0; i < 3; i++) tick();

    // Randomised traffic against the model.
    for (int t = 0; t < 300; t++) begin
      if0.registered_vld_i      = ($urandom_range(3) != 0);
      if0.registered_data_i     = 8'($urandom);
      if0.combinational_ready_i = ($urandom_range(4) < 3);
      if0.flush_i               = ($urandom_range(19) == 0);
      if1.registered_vld_i      = ($urandom_range(3) != 0);
      if1.registered_data_i     = 8'($urandom);
      if1.combinational_ready_i = ($urandom_range(4) < 3);
      if1.flush_i               = ($urandom_range(19) == 0);
      tick();
    end

    // T6: asynchronous reset mid-cycle while holding beats.
    if0.flush_i = 0; if1.flush_i = 0;
    if0.combinational_ready_i = 0; if1.combinational_ready_i = 0;
    if0.registered_vld_i = 1; if1.registered_vld_i = 1;
    for (int i = 0; i < 3; i++) begin
      if0.registered_data_i = 8'h31 + 8'(i);
      if1.registered_data_i = 8'h41 + 8'(i);
      tick();
    end
    if0.registered_vld_i = 0; if1.registered_vld_i = 0;
    #1;
    chk("t6_pre_cnt0", if0.count_o, q0.size());
    #1;
    rst = 1'b1;
    #1;
    chk("t6_cnt0", if0.count_o, 0);
    chk("t6_vld0", if0.cycle_vld_o, 1'b0);
    chk("t6_rdy0", if0.registered_ready_o, 1'b0);
    chk("t6_vld1", if1.cycle_vld_o, 1'b0);
    chk("t6_data1", if1.cycle_data_o, 8'h00);
    chk("t6_cnt1", if1.count_o, 0);
    q0.delete(); q1.delete(); rdy0 = 1'b0; rdy1 = 1'b0;
    @(negedge clk);
    tick();
    rst = 1'b0;
    tick();
    chk("t6_rel_rdy0", if0.registered_ready_o, 1'b1);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
